keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scans the 4x4 matrix keypad on GPIO_1 and debounces it. The block drives the column lines one at a time (active-low), samples the row lines, and applies full-scan debounce. It emits one validated hex key code per physical press, plus a held flag. It sits between the keypad pins and the lock FSM in FechaduraTop and runs on the divided clock.

Parameters:
SCAN_TICKS, 1000, clk cycles each column is driven low before rows are sampled (min 4).
DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or a release (min 1).

Ports:
clk  in  1  divided system clock
rst  in  1  asynchronous reset, active-low
scan_en  in  1  1 = scanning enabled; 0 = idle
matricial_lin  in  4  row inputs, pulled up, active-low; bit i = row i
matricial_col  out  4  column drives, active-low, one-hot-low while scanning; bit j = column j
key_valid  out  1  one-cycle pulse when a press is accepted
key_code  out  4  code of the last accepted key; held stable between pulses
key_held  out  1  high from the key_valid cycle until the release is accepted

Behaviour:
- Reset (rst=0, asynchronous): matricial_col=4'b1111, key_valid=0, key_code=0, key_held=0, FSM=SCAN, all counters 0.
- Row inputs pass through a 2-flop synchronizer before use.
- Column slot: column j is driven low for SCAN_TICKS cycles. Columns advance 0->1->2->3->0.
- Row sampling: synced rows are sampled on the last cycle of each slot (tick count = SCAN_TICKS-1).
- One full scan = 4*SCAN_TICKS cycles. Each scan produces one result:
  - NONE: no row low in any slot.
  - SINGLE(code): exactly one row low in exactly one slot.
  - MULTI: anything else (ghosting, two or more keys).
- Key map, (row,col) -> code:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: *=E, 0, #=F, D
- FSM states:
  - SCAN: SINGLE(c) -> load cand=c, stable_cnt=1, go DEB_PRESS (if DEBOUNCE_SCANS=1, accept immediately). NONE/MULTI -> stay.
  - DEB_PRESS: SINGLE(cand) -> stable_cnt++. When stable_cnt reaches DEBOUNCE_SCANS -> accept. SINGLE(other) -> cand=other, stable_cnt=1. NONE/MULTI -> back to SCAN.
  - Accept: in the cycle after the scan-end sample, key_valid=1 for one cycle, key_code=cand, key_held=1; go HELD.
  - HELD: NONE -> rel_cnt=1, go DEB_RELEASE. SINGLE/MULTI -> stay. There is no rollover: a different key pressed while held produces no new pulse.
  - DEB_RELEASE: NONE -> rel_cnt++. When rel_cnt reaches DEBOUNCE_SCANS -> key_held=0, go SCAN. SINGLE/MULTI -> back to HELD, key_held stays 1.
- Counter widths: $clog2(SCAN_TICKS) for the tick counter, $clog2(DEBOUNCE_SCANS+1) for stable_cnt/rel_cnt. Counters saturate and never wrap.
- scan_en=0, any state:
  - next cycle: matricial_col=4'b1111, FSM=SCAN, tick/column/debounce counters cleared, key_held=0, key_valid=0.
  - key_code holds its value.
  - When scan_en rises, scanning restarts at column 0.
- A key pressed through reset or scan_en re-enable is treated as a fresh press and produces a new key_valid.
- key_valid never asserts in two consecutive cycles. At most one pulse per press/release cycle.

Decomposition:
- Package keypad_pkg holds:
  - scan_state_t enum {SCAN, DEB_PRESS, HELD, DEB_RELEASE}
  - scan_res_t enum {RES_NONE, RES_SINGLE, RES_MULTI}
  - KEY_STAR=4'hE, KEY_HASH=4'hF
  - function keymap(row,col) returning the 4-bit code
- Sub-module keypad_col_driver: tick counter, column rotation, sample strobe, scan_end strobe, honours scan_en.
- The synchronizer, per-scan result accumulation and FSM stay in keypad_scan_ctrl.

Test Plan:
Common bench setup: SCAN_TICKS=4, DEBOUNCE_SCANS=3 (scan = 16 cycles). The keypad model pulls row r low only while its column drive is low.
- Clean press of '5' (row1,col1) held for 100 cycles -> exactly one key_valid, key_code=4'h5, within 4 scans + 4 cycles (<=68 cycles) of press. key_held=1 until 3 empty scans after release, then 0. No second pulse.
- '5' toggled every 5 cycles for 40 cycles, then held stable -> no key_valid during bounce; exactly one pulse with code 5 after the stable period.
- '1' and '9' held simultaneously -> no key_valid and key_held=0 throughout. Then release '9' and hold '1' -> one pulse, code 4'h1.
- '#' pressed, then '0' pressed while '#' is still held, then both released -> one pulse (code 4'hF) only; key_held drops after 3 empty scans.
- Reset asserted mid-HELD with '*' still pressed -> matricial_col=1111, key_valid=0, key_code=0, key_held=0 immediately. After deassertion, a new pulse with code 4'hE.
- scan_en=0 for 50 cycles while 'D' is pressed -> matricial_col=1111, no pulse, key_held=0. After re-enable, one pulse with code 4'hD.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} scan_state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} scan_res_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = '0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = 4'hD;
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_col_driver.sv
// Column rotation for the keypad: one active-low column per slot, with
// sample and scan-end strobes on the last tick of each slot.
module keypad_col_driver
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  output logic [3:0] col_n,
  output logic [1:0] col_idx,
  output logic       sample,
  output logic       scan_end
);

  localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

  logic          active;
  logic [TW-1:0] tick;
  logic [1:0]    col;

  // One idle cycle after enable so every scan starts cleanly at column 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      tick   <= '0;
      col    <= '0;
    end else if (!scan_en) begin
      active <= 1'b0;
      tick   <= '0;
      col    <= '0;
    end else begin
      active <= 1'b1;
      if (active) begin
        if (tick == TICK_LAST) begin
          tick <= '0;
          col  <= col + 2'd1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  always_comb begin
    col_n = '1;
    if (active) col_n[col] = 1'b0;
  end

  assign col_idx  = col;
  assign sample   = active && (tick == TICK_LAST);
  assign scan_end = sample && (col == 2'd3);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row synchronizer, per-scan result classification and
// press/release debounce FSM emitting one key_valid pulse per press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] matricial_lin,
  output logic [3:0] matricial_col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0] col_idx;
  logic       sample, scan_end;

  keypad_col_driver #(.SCAN_TICKS(SCAN_TICKS)) u_col_driver (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .col_n    (matricial_col),
    .col_idx  (col_idx),
    .sample   (sample),
    .scan_end (scan_end)
  );

  logic [3:0] lin_meta, lin_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lin_meta <= '1;
      lin_sync <= '1;
    end else begin
      lin_meta <= matricial_lin;
      lin_sync <= lin_meta;
    end
  end

  scan_res_t  acc_res, scan_res;
  logic [3:0] acc_code, scan_code;
  logic [2:0] slot_cnt;
  logic [1:0] slot_row;

  // scan_res/scan_code fold the current slot into the running result, so on
  // scan_end they already describe the complete scan.
  always_comb begin
    slot_cnt = '0;
    slot_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!lin_sync[i]) begin
        slot_cnt = slot_cnt + 3'd1;
        slot_row = 2'(i);
      end
    end
    scan_res  = acc_res;
    scan_code = acc_code;
    if (sample && slot_cnt != 3'd0) begin
      if (slot_cnt == 3'd1 && acc_res == RES_NONE) begin
        scan_res  = RES_SINGLE;
        scan_code = keymap(slot_row, col_idx);
      end else begin
        scan_res = RES_MULTI;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_res  <= RES_NONE;
      acc_code <= '0;
    end else if (!scan_en || scan_end) begin
      acc_res  <= RES_NONE;
      acc_code <= '0;
    end else if (sample) begin
      acc_res  <= scan_res;
      acc_code <= scan_code;
    end
  end

  scan_state_t   state;
  logic [3:0]    cand;
  logic [CW-1:0] stable_cnt, rel_cnt, stable_inc, rel_inc;

  assign stable_inc = (stable_cnt == DEB_MAX) ? stable_cnt : stable_cnt + 1'b1;
  assign rel_inc    = (rel_cnt == DEB_MAX) ? rel_cnt : rel_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      cand       <= '0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (!scan_en) begin
        state      <= SCAN;
        stable_cnt <= '0;
        rel_cnt    <= '0;
        key_held   <= 1'b0;
      end else if (scan_end) begin
        unique case (state)
          SCAN: begin
            if (scan_res == RES_SINGLE) begin
              cand       <= scan_code;
              stable_cnt <= CNT_ONE;
              if (CNT_ONE == DEB_MAX) begin
                key_valid <= 1'b1;
                key_code  <= scan_code;
                key_held  <= 1'b1;
                state     <= HELD;
              end else begin
                state <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (scan_res == RES_SINGLE && scan_code == cand) begin
              stable_cnt <= stable_inc;
              if (stable_inc == DEB_MAX) begin
                key_valid <= 1'b1;
                key_code  <= cand;
                key_held  <= 1'b1;
                state     <= HELD;
              end
            end else if (scan_res == RES_SINGLE) begin
              cand       <= scan_code;
              stable_cnt <= CNT_ONE;
            end else begin
              stable_cnt <= '0;
              state      <= SCAN;
            end
          end
          HELD: begin
            if (scan_res == RES_NONE) begin
              if (CNT_ONE == DEB_MAX) begin
                rel_cnt    <= '0;
                stable_cnt <= '0;
                key_held   <= 1'b0;
                state      <= SCAN;
              end else begin
                rel_cnt <= CNT_ONE;
                state   <= DEB_RELEASE;
              end
            end
          end
          DEB_RELEASE: begin
            if (scan_res == RES_NONE) begin
              if (rel_inc == DEB_MAX) begin
                rel_cnt    <= '0;
                stable_cnt <= '0;
                key_held   <= 1'b0;
                state      <= SCAN;
              end else begin
                rel_cnt <= rel_inc;
              end
            end else begin
              rel_cnt <= '0;
              state   <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: stimulus pushes expected key codes,
// a monitor pops them on every key_valid pulse.
module tb_keypad_scan_ctrl;

  localparam int unsigned ST = 4;
  localparam int unsigned DS = 3;
  localparam int          PRESS_BOUND = 68;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [3:0] matricial_lin;
  logic [3:0] matricial_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] pressed = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        prev_valid = 1'b0;

  typedef struct {
    logic [3:0] code;
    int         deadline;
  } exp_t;
  exp_t exp_q[$];

  // Index is row*4 + col.
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_ctrl #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clk           (clk),
    .rst           (rst),
    .scan_en       (scan_en),
    .matricial_lin (matricial_lin),
    .matricial_col (matricial_col),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_held      (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pressed key shorts its row to its column only while that column is driven low.
  always_comb begin
    matricial_lin = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4 + c] && !matricial_col[c]) matricial_lin[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      check("col_legal", matricial_col inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF}, 1);
      if (key_valid) begin
        check("no_back_to_back_valid", prev_valid, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: key_valid=1 code %0h at cycle %0d, expected no pulse", key_code, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_code", key_code, e.code);
          check("pulse_latency_within_bound", cyc <= e.deadline, 1);
          check("held_with_valid", key_held, 1);
        end
      end
      prev_valid = key_valid;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_key(input int k, input int bound);
    exp_t e;
    e.code = kmap[k];
    e.deadline = cyc + bound;
    exp_q.push_back(e);
  endtask

  task automatic expect_drained(input string name);
    check(name, exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic release_all_and_check(input logic [3:0] last_code);
    pressed = '0;
    wait_cycles(28);
    check("held_during_release_debounce", key_held, 1);
    wait_cycles(48);
    check("released_after_debounce", key_held, 0);
    check("code_holds_after_release", key_code, last_code);
  endtask

  task automatic press_key(input int k, input bit bounce, input int hold);
    if (bounce) begin
      for (int i = 0; i < 8; i++) begin
        pressed[k] = ~pressed[k];
        wait_cycles(5);
      end
    end
    pressed[k] = 1'b1;
    expect_key(k, PRESS_BOUND);
    wait_cycles(hold);
    expect_drained("press_pulse_arrived");
    check("held_while_pressed", key_held, 1);
    release_all_and_check(kmap[k]);
    wait_cycles($urandom_range(0, 20));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    scan_en = 1'b1;
    wait_cycles(3);
    check("reset_col", matricial_col, 4'hF);
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 0);
    check("reset_held", key_held, 0);
    rst = 1'b1;
    wait_cycles(10);

    // Clean press of '5', then bounced '5'.
    press_key(5, 1'b0, 100);
    press_key(5, 1'b1, 100);

    // Ghosting: '1' and '9' together must not produce a pulse.
    pressed[0] = 1'b1;
    pressed[10] = 1'b1;
    wait_cycles(100);
    check("ghost_no_held", key_held, 0);
    pressed[10] = 1'b0;
    expect_key(0, PRESS_BOUND);
    wait_cycles(80);
    expect_drained("ghost_resolved_pulse");
    release_all_and_check(4'h1);

    // No rollover: '0' pressed while '#' held.
    pressed[14] = 1'b1;
    expect_key(14, PRESS_BOUND);
    wait_cycles(80);
    expect_drained("hash_pulse");
    pressed[13] = 1'b1;
    wait_cycles(80);
    check("rollover_still_held", key_held, 1);
    check("rollover_code_kept", key_code, 4'hF);
    release_all_and_check(4'hF);

    // Asynchronous reset while '*' held.
    pressed[12] = 1'b1;
    expect_key(12, PRESS_BOUND);
    wait_cycles(80);
    expect_drained("star_pulse");
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_col", matricial_col, 4'hF);
    check("async_reset_valid", key_valid, 0);
    check("async_reset_code", key_code, 0);
    check("async_reset_held", key_held, 0);
    wait_cycles(3);
    rst = 1'b1;
    expect_key(12, PRESS_BOUND + 4);
    wait_cycles(80);
    expect_drained("star_pulse_after_reset");
    release_all_and_check(4'hE);

    // scan_en dropped while 'D' held.
    pressed[15] = 1'b1;
    expect_key(15, PRESS_BOUND);
    wait_cycles(80);
    expect_drained("d_pulse");
    scan_en = 1'b0;
    wait_cycles(2);
    check("disabled_col", matricial_col, 4'hF);
    check("disabled_held", key_held, 0);
    check("disabled_code_holds", key_code, 4'hD);
    wait_cycles(48);
    check("disabled_col_late", matricial_col, 4'hF);
    check("disabled_held_late", key_held, 0);
    scan_en = 1'b1;
    expect_key(15, PRESS_BOUND + 4);
    wait_cycles(80);
    expect_drained("d_pulse_after_enable");
    release_all_and_check(4'hD);

    // Randomized single-key presses, some with bounce.
    for (int i = 0; i < 12; i++) begin
      int k;
      k = $urandom_range(0, 15);
      press_key(k, 1'($urandom_range(0, 1)), $urandom_range(80, 160));
    end

    wait_cycles(20);
    expect_drained("final_queue_empty");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
